// File: rtl/trap_csr_unit_pkg.sv
// trap_csr_unit_pkg
//   Shared types and constants for the machine-mode CSR / trap unit:
//   CSR operation encoding, CSR address map, mstatus bit positions,
//   interrupt cause codes, and the read-modify-write helper.
package trap_csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus bit positions (the only implemented bits)
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Interrupt cause codes; also the bit positions in mie/mip
    localparam int IRQ_SW    = 3;
    localparam int IRQ_TIMER = 7;
    localparam int IRQ_EXT   = 11;

    // Writable bits of mie
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // Exception cause codes
    localparam logic [31:0] ILLEGAL_INST = 32'd2;

    // New CSR value for a read-modify-write operation.
    function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_val,
                                              logic [31:0] operand);
        case (op)
            CSR_RW:  return operand;
            CSR_RS:  return old_val | operand;
            CSR_RC:  return old_val & ~operand;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// trap_csr_unit_if
//   CSR access bus between the writeback stage (master) and the CSR file
//   (slave).
//   csr_valid/csr_addr/csr_op/csr_we/csr_wdata : request from writeback
//   csr_rdata   : old CSR value, combinational
//   csr_illegal : unknown address or write to a read-only CSR
interface trap_csr_unit_if;
    import trap_csr_unit_pkg::*;

    logic        csr_valid;
    logic [11:0] csr_addr;
    csr_op_t     csr_op;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_addr, csr_op, csr_we, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_addr, csr_op, csr_we, csr_wdata,
        output csr_rdata, csr_illegal
    );

endinterface

// File: rtl/trap_csr_unit_counter64.sv
// csr_counter64
//   64-bit performance counter with independently writable 32-bit halves.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance the counter by one this cycle
//   wr_lo    : replace bits [31:0] with wdata
//   wr_hi    : replace bits [63:32] with wdata
//   wdata    : write data for either half
//   value    : current 64-bit count
//   A write to either half suppresses the increment of the whole counter
//   for that cycle, so software sees exactly the value it wrote.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wdata;
            if (wr_hi) value[63:32] <= wdata;
        end else if (inc) begin
            value <= value + 64'd1;  // all-ones wraps to zero naturally
        end
    end

endmodule

// File: rtl/trap_csr_unit.sv
// trap_csr_unit
//   Machine-mode CSR file and trap state holder.
//   clk, rst            : clock, asynchronous active-high reset
//   csr                 : CSR access bus (slave side)
//   exception, exception_pc/cause/tval, is_interrupt : trap entry request
//   mret, return_pc     : trap return; return_pc always shows mepc
//   retire              : one instruction retired (minstret)
//   irq_sw/timer/ext    : level interrupt lines, registered into mip
//   interrupt_req/cause : highest-priority enabled pending interrupt
//   mtvec_base/mode     : trap vector fields for the trap-target logic
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    trap_csr_unit_if.slave        csr,
    input  logic                  exception,
    input  logic [31:0]           exception_pc,
    input  logic [31:0]           exception_cause,
    input  logic [31:0]           exception_tval,
    input  logic                  is_interrupt,
    input  logic                  mret,
    output logic [31:0]           return_pc,
    input  logic                  retire,
    input  logic                  irq_sw,
    input  logic                  irq_timer,
    input  logic                  irq_ext,
    output logic                  interrupt_req,
    output logic [31:0]           interrupt_cause,
    output logic [31:0]           mtvec_base,
    output logic [1:0]            mtvec_mode
);

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [2:0]  irq_q;        // {ext, timer, sw} as sampled last cycle
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mip;
    logic [31:0] rdata;
    logic        known;
    logic        wr_en;
    logic [31:0] wval;

    // Bit 31 of the incoming cause is replaced by is_interrupt.
    logic unused_cause_msb;
    assign unused_cause_msb = exception_cause[31];

    always_comb begin
        mip            = '0;
        mip[IRQ_SW]    = irq_q[0];
        mip[IRQ_TIMER] = irq_q[1];
        mip[IRQ_EXT]   = irq_q[2];
    end

    // NOTE: every always_comb output gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        rdata = '0;
        known = 1'b1;
        case (csr.csr_addr)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]  = mstatus_mie;
                rdata[MSTATUS_MPIE] = mstatus_mpie;
            end
            CSR_MISA:      rdata = MISA_VAL;
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip;
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MHARTID:   rdata = '0;
            default:       known = 1'b0;
        endcase
    end

    assign csr.csr_rdata   = rdata;
    assign csr.csr_illegal = csr.csr_valid &
                             (~known | (csr.csr_we &
                              ((csr.csr_addr == CSR_MISA) ||
                               (csr.csr_addr == CSR_MHARTID))));

    assign wr_en = csr.csr_valid & csr.csr_we & ~csr.csr_illegal;
    assign wval  = csr_apply(csr.csr_op, rdata, csr.csr_wdata);

    // Priority for the trap-related registers: exception > mret > CSR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= RESET_MTVEC;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            irq_q        <= '0;
        end else begin
            irq_q <= {irq_ext, irq_timer, irq_sw};

            if (exception) begin
                mepc_q       <= {exception_pc[31:2], 2'b00};
                mcause_q     <= {is_interrupt, exception_cause[30:0]};
                mtval_q      <= exception_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (wr_en && csr.csr_addr == CSR_MSTATUS) begin
                    mstatus_mie  <= wval[MSTATUS_MIE];
                    mstatus_mpie <= wval[MSTATUS_MPIE];
                end
                if (wr_en && csr.csr_addr == CSR_MEPC)   mepc_q   <= {wval[31:2], 2'b00};
                if (wr_en && csr.csr_addr == CSR_MCAUSE) mcause_q <= wval;
                if (wr_en && csr.csr_addr == CSR_MTVAL)  mtval_q  <= wval;
            end

            if (wr_en && csr.csr_addr == CSR_MIE)      mie_q      <= wval & MIE_MASK;
            if (wr_en && csr.csr_addr == CSR_MSCRATCH) mscratch_q <= wval;
            // Reserved vector modes (2, 3) fall back to direct mode.
            if (wr_en && csr.csr_addr == CSR_MTVEC)
                mtvec_q <= {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en && csr.csr_addr == CSR_MCYCLE),
        .wr_hi (wr_en && csr.csr_addr == CSR_MCYCLEH),
        .wdata (wval),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (wr_en && csr.csr_addr == CSR_MINSTRET),
        .wr_hi (wr_en && csr.csr_addr == CSR_MINSTRETH),
        .wdata (wval),
        .value (minstret)
    );

    // Interrupt selection: ext > sw > timer.
    logic [31:0] pend;
    assign pend = mie_q & mip;

    always_comb begin
        interrupt_req   = 1'b0;
        interrupt_cause = '0;
        if (mstatus_mie) begin
            if (pend[IRQ_EXT]) begin
                interrupt_req   = 1'b1;
                interrupt_cause = {1'b1, 31'(IRQ_EXT)};
            end else if (pend[IRQ_SW]) begin
                interrupt_req   = 1'b1;
                interrupt_cause = {1'b1, 31'(IRQ_SW)};
            end else if (pend[IRQ_TIMER]) begin
                interrupt_req   = 1'b1;
                interrupt_cause = {1'b1, 31'(IRQ_TIMER)};
            end
        end
    end

    assign return_pc  = mepc_q;
    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    assign mtvec_mode = mtvec_q[1:0];

endmodule
